timer_seq_ctrl: RTL and testbench
=================================

Name: timer_seq_ctrl

Overview:
- AXI write-only master that programs and sequences one timer peripheral: loads the trigger value, enables count and interrupt, services each interrupt by write-clearing the trigger bit, counts events, then disables the timer.
- Sits between a core-side control register block and the peripheral AXI port of the timer. Single-beat transactions only, so no cache or burst path is involved.

Parameters:
- BASE_ADDR, 32'h0000_0000: timer base address. Register offsets: STATE 0x0, COUNT 0x4, VALUE 0x8.
- CNT_W, 16: width of the event target and event counter.
- WDOG_MAX, 65536: watchdog limit in cycles for WAIT_IRQ. Used only with TMR_SEQ_WDOG_EN.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- start_i  in  1  start pulse; accepted only when busy_o=0.
- stop_i  in  1  abort request; honoured while busy_o=1.
- period_i  in  32  trigger value, sampled when start_i is accepted.
- events_i  in  CNT_W  event target, sampled when start_i is accepted; 0 = free-running until stop_i.
- irq_i  in  1  timer interrupt, level.
- busy_o  out  1  high from start acceptance to the end of the DISABLE write.
- done_o  out  1  one-cycle pulse when the sequence ends.
- err_o  out  1  sticky error flag.
- evt_cnt_o  out  CNT_W  number of interrupts serviced.
- M_AXI_AWADDR  out  32  write address, BASE_ADDR+offset.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- Top-level ties ID=0, LEN=0, SIZE=3'b010, BURST=2'b01.

Behaviour:
- Reset (async): state=IDLE; every output 0 except WSTRB=4'hF; stop-pending flag cleared. A reset mid-transaction drops AWVALID and WVALID immediately.
- States: IDLE, WR_VAL, WR_EN, WAIT_IRQ, WR_CLR, WR_DIS.
  - IDLE + start_i → WR_VAL. Latch period_i and events_i; clear evt_cnt_o and err_o; busy_o=1 next cycle.
  - WR_VAL writes VALUE=period, then → WR_EN.
  - WR_EN writes STATE=32'h3, then → WAIT_IRQ.
  - WAIT_IRQ: when irq_i=1, evt_cnt_o+1 and → WR_CLR.
  - WR_CLR writes STATE=32'h7 (bit2 write-clears the trigger; enables stay set). Next state is WR_DIS if events_i!=0 and evt_cnt_o==events_i, or if stop is pending; otherwise WAIT_IRQ.
  - WR_DIS writes STATE=32'h0. On its B handshake → IDLE, done_o pulses 1 cycle, busy_o=0 the same cycle.
- Write state protocol:
  - On state entry, AWVALID, WVALID and BREADY are asserted, all registered.
  - AWVALID and WVALID each deassert on the cycle after their own VALID&&READY edge. Each channel completes exactly once per write.
  - BREADY stays high until the B handshake. The state advances on the B handshake only when both AW and W have completed.
  - Minimum write latency with an always-ready slave: 2 cycles (entry cycle plus the handshake edge).
- irq_i is level-sampled only in WAIT_IRQ. A residual irq_i during the clear write is ignored. evt_cnt_o saturates at all-ones.
- stop_i:
  - In WAIT_IRQ: → WR_DIS next cycle.
  - In a write state: sets the stop-pending flag. The current write completes, then → WR_DIS (from WR_DIS itself, no extra write).
  - In IDLE: ignored.
- start_i while busy is ignored. start_i and stop_i together in IDLE: start wins and stop is ignored.
- Any BRESP!=2'b00 sets err_o (sticky until the next accepted start). The sequence continues unchanged.

Optional Feature:
- TMR_SEQ_WDOG_EN defined:
  - A 32-bit cycle counter clears on WAIT_IRQ entry and increments while in WAIT_IRQ.
  - When it reaches WDOG_MAX: err_o=1 and → WR_DIS.
- TMR_SEQ_WDOG_EN undefined: no counter is built, and WAIT_IRQ waits indefinitely.

Test Plan:
- Always-ready slave, BVALID one cycle after W; start with period=10, events=3; irq pulse about 12 cycles after each enable/clear → writes, in order: 0x8←10, 0x0←3, 0x0←7 ×3, 0x0←0. Then done_o=1 for 1 cycle, evt_cnt_o=3, busy_o=0.
- AWREADY delayed 3 cycles, WREADY ready immediately → WVALID drops after 1 handshake; AWVALID held until its handshake; exactly one AW, one W and one B per register write.
- events=0, stop_i pulsed in WAIT_IRQ after 2 interrupts → single write 0x0←0, done_o pulse, evt_cnt_o=2.
- BRESP=2'b10 on the VALUE write → err_o=1 stays set through the remaining sequence; a new start_i clears it.
- ARESET asserted with AWVALID=1 mid-WR_EN → AWVALID, WVALID, BREADY, busy_o and evt_cnt_o are 0 before the next clock edge; state returns to IDLE.

Source files
------------

// File: rtl/timer_seq_ctrl.sv
// Single-beat AXI write master that programs one timer, services its interrupts and disables it.
// Optional WAIT_IRQ watchdog is built only when TMR_SEQ_WDOG_EN is defined.
module timer_seq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
`ifdef TMR_SEQ_WDOG_EN
    ,
    parameter int          WDOG_MAX  = 65536
`endif
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [31:0]      period_i,
    input  logic [CNT_W-1:0] events_i,
    input  logic             irq_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic [31:0]      M_AXI_AWADDR,
    output logic             M_AXI_AWVALID,
    input  logic             M_AXI_AWREADY,
    output logic [31:0]      M_AXI_WDATA,
    output logic [3:0]       M_AXI_WSTRB,
    output logic             M_AXI_WVALID,
    input  logic             M_AXI_WREADY,
    input  logic [1:0]       M_AXI_BRESP,
    input  logic             M_AXI_BVALID,
    output logic             M_AXI_BREADY
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_VAL   = 3'd1,
        WR_EN    = 3'd2,
        WAIT_IRQ = 3'd3,
        WR_CLR   = 3'd4,
        WR_DIS   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic is_wr_f(input state_t s);
        case (s)
            WR_VAL, WR_EN, WR_CLR, WR_DIS: is_wr_f = 1'b1;
            default:                       is_wr_f = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wr_off_f(input state_t s);
        case (s)
            WR_VAL:  wr_off_f = 32'h0000_0008;
            default: wr_off_f = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] wr_data_f(input state_t s, input logic [31:0] period);
        case (s)
            WR_VAL:  wr_data_f = period;
            WR_EN:   wr_data_f = 32'h0000_0003;
            WR_CLR:  wr_data_f = 32'h0000_0007;
            default: wr_data_f = 32'h0000_0000;
        endcase
    endfunction

    state_t           state_r;
    state_t           nxt_state_s;
    logic             awvalid_r;
    logic             wvalid_r;
    logic             bready_r;
    logic             aw_done_r;
    logic             w_done_r;
    logic             b_done_r;
    logic [31:0]      awaddr_r;
    logic [31:0]      wdata_r;
    logic [CNT_W-1:0] events_r;
    logic [CNT_W-1:0] evt_cnt_r;
    logic             stop_pend_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             aw_ok_s;
    logic             w_ok_s;
    logic             b_ok_s;
    logic             wr_fin_s;
    logic             stop_any_s;
    logic             tgt_hit_s;
    logic             enter_wr_s;
    logic             wdog_hit_s;

`ifdef TMR_SEQ_WDOG_EN
    logic [31:0]      wdog_cnt_r;
`endif

    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign err_o         = err_r;
    assign evt_cnt_o     = evt_cnt_r;
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;

    // Write completion: each channel counts as done once its handshake has happened or is happening now.
    always_comb begin
        aw_ok_s    = aw_done_r | (awvalid_r & M_AXI_AWREADY);
        w_ok_s     = w_done_r  | (wvalid_r  & M_AXI_WREADY);
        b_ok_s     = b_done_r  | (bready_r  & M_AXI_BVALID);
        wr_fin_s   = is_wr_f(state_r) & aw_ok_s & w_ok_s & b_ok_s;
        stop_any_s = stop_pend_r | stop_i;
        tgt_hit_s  = (events_r != CNT_ZERO) && (evt_cnt_r == events_r);
`ifdef TMR_SEQ_WDOG_EN
        wdog_hit_s = (state_r == WAIT_IRQ) && (wdog_cnt_r == 32'(WDOG_MAX)) && !stop_i && !irq_i;
`else
        wdog_hit_s = 1'b0;
`endif
    end

    // Next-state selection for the sequencer.
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) nxt_state_s = WR_VAL;
                else         nxt_state_s = IDLE;
            end
            WR_VAL: begin
                if (wr_fin_s) nxt_state_s = stop_any_s ? WR_DIS : WR_EN;
                else          nxt_state_s = WR_VAL;
            end
            WR_EN: begin
                if (wr_fin_s) nxt_state_s = stop_any_s ? WR_DIS : WAIT_IRQ;
                else          nxt_state_s = WR_EN;
            end
            WAIT_IRQ: begin
                if (stop_i)          nxt_state_s = WR_DIS;
                else if (irq_i)      nxt_state_s = WR_CLR;
                else if (wdog_hit_s) nxt_state_s = WR_DIS;
                else                 nxt_state_s = WAIT_IRQ;
            end
            WR_CLR: begin
                if (wr_fin_s) nxt_state_s = (stop_any_s || tgt_hit_s) ? WR_DIS : WAIT_IRQ;
                else          nxt_state_s = WR_CLR;
            end
            WR_DIS: begin
                if (wr_fin_s) nxt_state_s = IDLE;
                else          nxt_state_s = WR_DIS;
            end
            default: nxt_state_s = IDLE;
        endcase
        enter_wr_s = (nxt_state_s != state_r) && is_wr_f(nxt_state_s);
    end

    // Sequencer state, AXI channel control and status registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r     <= IDLE;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            b_done_r    <= 1'b0;
            awaddr_r    <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            events_r    <= CNT_ZERO;
            evt_cnt_r   <= CNT_ZERO;
            stop_pend_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef TMR_SEQ_WDOG_EN
            wdog_cnt_r  <= 32'd0;
`endif
        end else begin
            state_r <= nxt_state_s;
            done_r  <= 1'b0;

            if (awvalid_r && M_AXI_AWREADY) begin
                awvalid_r <= 1'b0;
                aw_done_r <= 1'b1;
            end
            if (wvalid_r && M_AXI_WREADY) begin
                wvalid_r <= 1'b0;
                w_done_r <= 1'b1;
            end
            if (bready_r && M_AXI_BVALID) begin
                bready_r <= 1'b0;
                b_done_r <= 1'b1;
                if (M_AXI_BRESP != 2'b00) err_r <= 1'b1;
            end

            // A fresh write overrides the completion flags of the one just finished.
            if (enter_wr_s) begin
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
                bready_r  <= 1'b1;
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
                b_done_r  <= 1'b0;
                awaddr_r  <= BASE_ADDR + wr_off_f(nxt_state_s);
                wdata_r   <= wr_data_f(nxt_state_s, period_i);
            end

            if (is_wr_f(state_r) && stop_i) stop_pend_r <= 1'b1;

            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        events_r    <= events_i;
                        evt_cnt_r   <= CNT_ZERO;
                        err_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        stop_pend_r <= 1'b0;
                    end
                end
                WAIT_IRQ: begin
                    if ((nxt_state_s == WR_CLR) && (evt_cnt_r != CNT_MAX))
                        evt_cnt_r <= evt_cnt_r + CNT_W'(1);
                end
                WR_DIS: begin
                    if (wr_fin_s) begin
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        stop_pend_r <= 1'b0;
                    end
                end
                default: ;
            endcase

`ifdef TMR_SEQ_WDOG_EN
            if (state_r != WAIT_IRQ) wdog_cnt_r <= 32'd0;
            else                     wdog_cnt_r <= wdog_cnt_r + 32'd1;
            if (wdog_hit_s) err_r <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl: behavioural AXI write slave, handshake log and per-scenario checks.
module tb_timer_seq_ctrl;

    logic        ACLK;
    logic        ARESET;
    logic        start_i;
    logic        stop_i;
    logic [31:0] period_i;
    logic [15:0] events_i;
    logic        irq_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] evt_cnt_o;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    int n_pass  = 0;
    int n_total = 0;

    int aw_cnt = 0;
    int w_cnt  = 0;
    int b_cnt  = 0;
    logic [31:0] aw_log [0:63];
    logic [31:0] w_log  [0:63];

    int aw_dly = 0;
    int w_dly  = 0;
    int err_at = -1;

    timer_seq_ctrl #(.BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .start_i(start_i), .stop_i(stop_i), .period_i(period_i), .events_i(events_i), .irq_i(irq_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .evt_cnt_o(evt_cnt_o),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Handshake log, sampled on the active edge.
    always @(posedge ACLK) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            if (aw_cnt < 64) aw_log[aw_cnt] = M_AXI_AWADDR;
            aw_cnt = aw_cnt + 1;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
            if (w_cnt < 64) w_log[w_cnt] = M_AXI_WDATA;
            w_cnt = w_cnt + 1;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_cnt = b_cnt + 1;
    end

    // Slave: READY after a programmable delay, BVALID once both AW and W of a write are accepted.
    initial begin
        int aw_wait;
        int w_wait;
        aw_wait = 0;
        w_wait  = 0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        forever begin
            @(negedge ACLK);
            if (M_AXI_AWVALID) begin
                if (aw_wait >= aw_dly) M_AXI_AWREADY = 1'b1;
                else begin M_AXI_AWREADY = 1'b0; aw_wait = aw_wait + 1; end
            end else begin
                M_AXI_AWREADY = 1'b0;
                aw_wait = 0;
            end
            if (M_AXI_WVALID) begin
                if (w_wait >= w_dly) M_AXI_WREADY = 1'b1;
                else begin M_AXI_WREADY = 1'b0; w_wait = w_wait + 1; end
            end else begin
                M_AXI_WREADY = 1'b0;
                w_wait = 0;
            end
            if (aw_cnt > b_cnt && w_cnt > b_cnt) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = (b_cnt == err_at) ? 2'b10 : 2'b00;
            end else begin
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP  = 2'b00;
            end
        end
    end

    task automatic wait_b(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic do_start(input logic [31:0] p, input logic [15:0] e);
        period_i = p;
        events_i = e;
        start_i  = 1'b1;
        @(negedge ACLK);
        start_i  = 1'b0;
    endtask

    task automatic pulse_irq(input int gap);
        repeat (gap) @(negedge ACLK);
        irq_i = 1'b1;
        @(negedge ACLK);
        irq_i = 1'b0;
    endtask

    task automatic pulse_stop(input int gap);
        repeat (gap) @(negedge ACLK);
        stop_i = 1'b1;
        @(negedge ACLK);
        stop_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] obs;
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        obs = {busy_o, done_o, err_o, (evt_cnt_o != 16'd0), M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY};
        n_total++;
        if (obs !== 7'b0) $display("FAIL reset_outputs: got %b expected 0000000", obs);
        else n_pass++;
        n_total++;
        if (M_AXI_WSTRB !== 4'hF) $display("FAIL reset_wstrb: got %h expected f", M_AXI_WSTRB);
        else n_pass++;
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_full_seq;
        logic [31:0] exp_a [6] = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] exp_d [6] = '{32'd10, 32'h3, 32'h7, 32'h7, 32'h7, 32'h0};
        int base;
        bit ok;
        base = b_cnt;
        do_start(32'd10, 16'd3);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL seq_busy_start: got %b expected 1", busy_o);
        else n_pass++;
        wait_b(base + 2, ok);
        for (int k = 1; k <= 3; k++) begin
            pulse_irq(12);
            wait_b(base + 2 + k, ok);
        end
        wait_b(base + 6, ok);
        n_total++;
        if (!ok) $display("FAIL seq_timeout: got %0d writes expected 6", b_cnt - base);
        else n_pass++;
        n_total++;
        if ({done_o, busy_o} !== 2'b10) $display("FAIL seq_done_busy: got %b expected 10", {done_o, busy_o});
        else n_pass++;
        n_total++;
        if (evt_cnt_o !== 16'd3) $display("FAIL seq_evt_cnt: got %0d expected 3", evt_cnt_o);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (aw_log[base + i] !== exp_a[i] || w_log[base + i] !== exp_d[i])
                $display("FAIL seq_write%0d: got %h<-%h expected %h<-%h", i,
                         aw_log[base + i], w_log[base + i], exp_a[i], exp_d[i]);
            else n_pass++;
        end
        @(negedge ACLK);
        n_total++;
        if (done_o !== 1'b0) $display("FAIL seq_done_one_cycle: got %b expected 0", done_o);
        else n_pass++;
    endtask

    task automatic test_aw_delay;
        int base;
        bit ok;
        base = b_cnt;
        aw_dly = 3;
        do_start(32'd5, 16'd1);
        @(negedge ACLK);
        n_total++;
        if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b10)
            $display("FAIL awdly_valids: got %b expected 10", {M_AXI_AWVALID, M_AXI_WVALID});
        else n_pass++;
        wait_b(base + 2, ok);
        pulse_irq(4);
        wait_b(base + 4, ok);
        n_total++;
        if (!ok || done_o !== 1'b1) $display("FAIL awdly_done: got %b expected 1", done_o);
        else n_pass++;
        n_total++;
        if ({aw_cnt - base, w_cnt - base, b_cnt - base} !== {32'd4, 32'd4, 32'd4})
            $display("FAIL awdly_counts: got aw=%0d w=%0d b=%0d expected 4 4 4",
                     aw_cnt - base, w_cnt - base, b_cnt - base);
        else n_pass++;
        n_total++;
        if (aw_log[base] !== 32'h8 || w_log[base] !== 32'd5 || w_log[base + 2] !== 32'h7)
            $display("FAIL awdly_data: got %h<-%h,%h expected 8<-5,7",
                     aw_log[base], w_log[base], w_log[base + 2]);
        else n_pass++;
        aw_dly = 0;
        @(negedge ACLK);
    endtask

    task automatic test_stop_free_run;
        int base;
        bit ok;
        base = b_cnt;
        do_start(32'd20, 16'd0);
        wait_b(base + 2, ok);
        pulse_irq(12);
        wait_b(base + 3, ok);
        pulse_irq(12);
        wait_b(base + 4, ok);
        pulse_stop(3);
        wait_b(base + 5, ok);
        n_total++;
        if (!ok || {done_o, busy_o} !== 2'b10)
            $display("FAIL stop_done: got %b expected 10", {done_o, busy_o});
        else n_pass++;
        n_total++;
        if (evt_cnt_o !== 16'd2) $display("FAIL stop_evt_cnt: got %0d expected 2", evt_cnt_o);
        else n_pass++;
        n_total++;
        if (aw_log[base + 4] !== 32'h0 || w_log[base + 4] !== 32'h0)
            $display("FAIL stop_dis_write: got %h<-%h expected 0<-0", aw_log[base + 4], w_log[base + 4]);
        else n_pass++;
        repeat (3) @(negedge ACLK);
        n_total++;
        if (b_cnt - base !== 5) $display("FAIL stop_write_count: got %0d expected 5", b_cnt - base);
        else n_pass++;
    endtask

    task automatic test_start_stop;
        int base;
        bit ok;
        base = b_cnt;
        stop_i = 1'b1;
        do_start(32'd4, 16'd0);
        stop_i = 1'b0;
        wait_b(base + 2, ok);
        repeat (3) @(negedge ACLK);
        n_total++;
        if (b_cnt - base !== 2 || busy_o !== 1'b1)
            $display("FAIL startstop_ignored: got writes=%0d busy=%b expected 2 1", b_cnt - base, busy_o);
        else n_pass++;
        pulse_stop(0);
        wait_b(base + 3, ok);
        n_total++;
        if (!ok || done_o !== 1'b1 || w_log[base + 2] !== 32'h0)
            $display("FAIL startstop_end: got done=%b data=%h expected 1 0", done_o, w_log[base + 2]);
        else n_pass++;
        @(negedge ACLK);
    endtask

    task automatic test_stop_pending;
        int base;
        bit ok;
        base = b_cnt;
        do_start(32'd7, 16'd0);
        pulse_stop(0);
        wait_b(base + 2, ok);
        n_total++;
        if (!ok || done_o !== 1'b1) $display("FAIL pend_done: got %b expected 1", done_o);
        else n_pass++;
        n_total++;
        if (w_log[base] !== 32'd7 || aw_log[base + 1] !== 32'h0 || w_log[base + 1] !== 32'h0)
            $display("FAIL pend_writes: got %h,%h<-%h expected 7,0<-0",
                     w_log[base], aw_log[base + 1], w_log[base + 1]);
        else n_pass++;
        @(negedge ACLK);
    endtask

    task automatic test_bresp_err;
        int base;
        bit ok;
        base = b_cnt;
        err_at = base;
        do_start(32'd9, 16'd1);
        wait_b(base + 1, ok);
        n_total++;
        if (err_o !== 1'b1) $display("FAIL err_set: got %b expected 1", err_o);
        else n_pass++;
        wait_b(base + 2, ok);
        pulse_irq(5);
        wait_b(base + 4, ok);
        n_total++;
        if (!ok || {err_o, done_o} !== 2'b11) $display("FAIL err_sticky: got %b expected 11", {err_o, done_o});
        else n_pass++;
        err_at = -1;
        @(negedge ACLK);
        do_start(32'd9, 16'd1);
        n_total++;
        if ({err_o, busy_o} !== 2'b01) $display("FAIL err_clear: got %b expected 01", {err_o, busy_o});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        base = b_cnt;
        wait_b(base + 1, ok);
        n_total++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'h0)
            $display("FAIL rstmid_pre: got %b %h expected 1 0", M_AXI_AWVALID, M_AXI_AWADDR);
        else n_pass++;
        ARESET = 1'b1;
        #1;
        n_total++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, busy_o, (evt_cnt_o != 16'd0)} !== 5'b0)
            $display("FAIL rstmid_async: got %b expected 00000",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, busy_o, (evt_cnt_o != 16'd0)});
        else n_pass++;
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        n_total++;
        if ({M_AXI_AWVALID, busy_o} !== 2'b00)
            $display("FAIL rstmid_idle: got %b expected 00", {M_AXI_AWVALID, busy_o});
        else n_pass++;
    endtask

    initial begin
        ARESET   = 1'b1;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        period_i = 32'd0;
        events_i = 16'd0;
        irq_i    = 1'b0;
        @(negedge ACLK);
        test_reset;
        test_full_seq;
        test_aw_delay;
        test_stop_free_run;
        test_start_stop;
        test_stop_pending;
        test_bresp_err;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
